// File: rtl/xl_sender_if.sv
// xl_sender_if: request inputs and serial/status outputs of xl_sender.
// master drives the request side; slave is the transmitter.
interface xl_sender_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [3:0]       repeat_n;
  logic             check;
  logic             busy;
  logic             done;
  logic [7:0]       frame_cnt;

  modport master (
    output start, data, repeat_n,
    input  check, busy, done, frame_cnt
  );

  modport slave (
    input  start, data, repeat_n,
    output check, busy, done, frame_cnt
  );
endinterface

// File: rtl/xl_sender.sv
// xl_sender: sends a captured frame MSB-first on check, repeated N times with logic-1 gaps.
// Define XL_SENDER_PARITY_EN to append an even-parity bit after bit 0 of every frame.
module xl_sender #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  xl_sender_if.slave bus
);

  localparam int unsigned  BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
`ifdef XL_SENDER_PARITY_EN
    S_PARITY,
`endif
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state,  w_state;
  logic [WIDTH-1:0] r_data,   w_data;
  logic [WIDTH-1:0] r_shreg,  w_shreg;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt;
  logic [3:0]       r_gap_cnt, w_gap_cnt;
  logic [3:0]       r_rem,    w_rem;
  logic             r_check,  w_check;
  logic             r_busy,   w_busy;
  logic             r_done,   w_done;
  logic [7:0]       r_frame_cnt, w_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_rem       <= '0;
      r_check     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_data      <= w_data;
      r_shreg     <= w_shreg;
      r_bit_cnt   <= w_bit_cnt;
      r_gap_cnt   <= w_gap_cnt;
      r_rem       <= w_rem;
      r_check     <= w_check;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_frame_cnt <= w_frame_cnt;
    end
  end

  // Outputs are computed for the next state and registered, so check always
  // carries the bit belonging to the state held in r_state.
  always_comb begin
    w_state     = r_state;
    w_data      = r_data;
    w_shreg     = r_shreg;
    w_bit_cnt   = r_bit_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_rem       = r_rem;
    w_check     = 1'b1;
    w_done      = 1'b0;
    w_frame_cnt = r_frame_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state   = S_SHIFT;
          w_data    = bus.data;
          w_check   = bus.data[WIDTH-1];
          w_shreg   = bus.data << 1;
          w_bit_cnt = LAST_BIT;
          w_rem     = (bus.repeat_n == 4'd0) ? 4'd1 : bus.repeat_n;
        end
      end

      S_SHIFT: begin
        if (r_bit_cnt != '0) begin
          w_check   = r_shreg[WIDTH-1];
          w_shreg   = r_shreg << 1;
          w_bit_cnt = r_bit_cnt - BW'(1);
        end else begin
`ifdef XL_SENDER_PARITY_EN
          w_state   = S_PARITY;
          w_check   = ^r_data;
`else
          w_state   = S_GAP;
          w_gap_cnt = GAP_LAST;
`endif
        end
      end

`ifdef XL_SENDER_PARITY_EN
      S_PARITY: begin
        w_state   = S_GAP;
        w_gap_cnt = GAP_LAST;
      end
`endif

      S_GAP: begin
        if (r_gap_cnt != '0) begin
          w_gap_cnt = r_gap_cnt - 4'd1;
        end else begin
          w_frame_cnt = r_frame_cnt + 8'd1;
          if (r_rem > 4'd1) begin
            w_rem     = r_rem - 4'd1;
            w_state   = S_SHIFT;
            w_check   = r_data[WIDTH-1];
            w_shreg   = r_data << 1;
            w_bit_cnt = LAST_BIT;
          end else begin
            w_rem   = '0;
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end

      S_DONE: w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE) && (w_state != S_DONE);
  end

  assign bus.check     = r_check;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_xl_sender.sv
// tb_xl_sender: table vectors, hand-written corner sequences and random transfers
// checked cycle by cycle against an expected bit-stream queue built from the frame rules.
`timescale 1ns/1ps
module tb_xl_sender;

  localparam int W = 8;
  localparam int G = 2;
`ifdef XL_SENDER_PARITY_EN
  localparam int F = W + 1 + G;
`else
  localparam int F = W + G;
`endif

  logic clk = 1'b0;
  logic rst_n;

  xl_sender_if #(.WIDTH(W)) bus();

  xl_sender #(.WIDTH(W), .GAP(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_fc = '0;
  int         total_frames = 0;

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  rep;
    int          exp_n;
    logic [15:0] exp_head;  // check values over the first F cycles, first cycle in the MSB
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic ec, input logic eb,
                     input logic ed, input logic [7:0] ef);
    n_vec++;
    if (bus.check !== ec || bus.busy !== eb || bus.done !== ed || bus.frame_cnt !== ef) begin
      n_err++;
      $display("FAIL %s t=%0t: got check=%b busy=%b done=%b frame_cnt=%0d, want check=%b busy=%b done=%b frame_cnt=%0d",
               name, $time, bus.check, bus.busy, bus.done, bus.frame_cnt, ec, eb, ed, ef);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle
  // cycle that follows done, where a new start may be presented.
  task automatic do_xfer(input logic [7:0] d, input logic [3:0] r, input int n,
                         input bit hold, input bit junk, output logic [15:0] cap);
    bit         q[$];
    int         busy_cycles;
    logic [7:0] base;
    base        = exp_fc;
    cap         = '0;
    busy_cycles = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < W; j++) q.push_back(d[W-1-j]);
`ifdef XL_SENDER_PARITY_EN
      q.push_back(^d);
`endif
      for (int g = 0; g < G; g++) q.push_back(1'b1);
    end
    bus.start    = 1'b1;
    bus.data     = d;
    bus.repeat_n = r;
    @(posedge clk);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (!hold) bus.start = junk ? 1'($urandom) : 1'b0;
      if (junk) begin
        bus.data     = 8'($urandom);
        bus.repeat_n = 4'($urandom);
      end
      if (i < F) cap = {cap[14:0], bus.check};
      if (bus.busy === 1'b1) busy_cycles++;
      chk("stream", q[i], 1'b1, 1'b0, base + 8'(i / F));
    end
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    chk("done_cycle", 1'b1, 1'b0, 1'b1, base + 8'(n));
    chk_int("busy_len", busy_cycles, n * F);
    exp_fc       = base + 8'(n);
    total_frames = total_frames + n;
    @(negedge clk);
    chk("idle_after_done", 1'b1, 1'b0, 1'b0, exp_fc);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    logic [7:0]  d;
    logic [3:0]  r;

`ifdef XL_SENDER_PARITY_EN
    tbl[0] = '{8'h45, 4'd1,  1,  16'b01000101_1_11};
    tbl[1] = '{8'hA5, 4'd3,  3,  16'b10100101_0_11};
    tbl[2] = '{8'h3C, 4'd0,  1,  16'b00111100_0_11};
    tbl[3] = '{8'hFF, 4'd15, 15, 16'b11111111_0_11};
    tbl[4] = '{8'h07, 4'd2,  2,  16'b00000111_1_11};
`else
    tbl[0] = '{8'h45, 4'd1,  1,  16'b01000101_11};
    tbl[1] = '{8'hA5, 4'd3,  3,  16'b10100101_11};
    tbl[2] = '{8'h3C, 4'd0,  1,  16'b00111100_11};
    tbl[3] = '{8'hFF, 4'd15, 15, 16'b11111111_11};
    tbl[4] = '{8'h07, 4'd2,  2,  16'b00000111_11};
`endif

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.data     = '0;
    bus.repeat_n = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 1'b1, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 5; i++) begin
      do_xfer(tbl[i].data, tbl[i].rep, tbl[i].exp_n, 1'b0, 1'b0, cap);
      chk_int("frame_head", int'(cap), int'(tbl[i].exp_head));
    end

    // start held high with data scrambled mid-frame; the follow-on transfer
    // takes the data presented in the single idle cycle after done.
    do_xfer(8'h96, 4'd1, 1, 1'b1, 1'b1, cap);
`ifdef XL_SENDER_PARITY_EN
    chk_int("hold_first_head", int'(cap), int'(16'b10010110_0_11));
`else
    chk_int("hold_first_head", int'(cap), int'(16'b10010110_11));
`endif
    do_xfer(8'h69, 4'd1, 1, 1'b0, 1'b0, cap);
`ifdef XL_SENDER_PARITY_EN
    chk_int("hold_second_head", int'(cap), int'(16'b01101001_0_11));
`else
    chk_int("hold_second_head", int'(cap), int'(16'b01101001_11));
`endif

    // Reset during bit 4 of frame 2 of a 3-frame transfer of 8'hF0 (that bit is 0).
    bus.start    = 1'b1;
    bus.data     = 8'hF0;
    bus.repeat_n = 4'd3;
    @(posedge clk);
    for (int i = 0; i <= 2 * F + 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("before_abort", 1'b0, 1'b1, 1'b0, exp_fc + 8'd2);
    #2 rst_n = 1'b0;
    #1 chk("async_abort", 1'b1, 1'b0, 1'b0, 8'd0);
    exp_fc       = '0;
    total_frames = 0;
    repeat (2) begin
      @(negedge clk);
      chk("held_in_reset", 1'b1, 1'b0, 1'b0, 8'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_abort", 1'b1, 1'b0, 1'b0, 8'd0);
    end

    for (int it = 0; it < 30; it++) begin
      d = 8'($urandom);
      r = 4'($urandom_range(0, 15));
      do_xfer(d, r, (r == 4'd0) ? 1 : int'(r), 1'b0, 1'b1, cap);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("random_idle", 1'b1, 1'b0, 1'b0, exp_fc);
      end
    end

    // Push frame_cnt past 255 so the wrap is observed.
    while (total_frames < 270) begin
      d = 8'($urandom);
      do_xfer(d, 4'd15, 15, 1'b0, 1'b1, cap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
